// File: rtl/aoi221_exerciser_pkg.sv
// Shared types, constants and the reference function for the AOI221 exerciser.
package aoi221_exerciser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 32;
    localparam int VEC_W       = 5;
    // Wide enough for the largest legal settle interval (15).
    localparam int SETTLE_W    = 4;

    // Reference output of the cell for vector {a1,a2,b1,b2,c}.
    function automatic logic aoi221_expect(input logic [VEC_W-1:0] vec);
        return !((vec[4] & vec[3]) | (vec[2] & vec[1]) | vec[0]);
    endfunction

endpackage

// File: rtl/aoi221_exerciser_if.sv
// Cell-drive and result bundle between the exerciser and its harness.
interface aoi221_exerciser_if
    import aoi221_exerciser_pkg::*;
#(
    parameter int ERR_CNT_W = 6
) ();

    logic                 start;
    logic                 a1;
    logic                 a2;
    logic                 b1;
    logic                 b2;
    logic                 c;
    logic                 zn;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [VEC_W-1:0]     fail_vec;

    // The exerciser drives the cell and publishes results.
    modport master (
        input  start, zn,
        output a1, a2, b1, b2, c, busy, done, pass, err_cnt, fail_vec
    );

    // The harness requests runs, supplies the cell output and reads results.
    modport slave (
        output start, zn,
        input  a1, a2, b1, b2, c, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/aoi221_exerciser_sat_cnt.sv
// Clearable up-counter that sticks at its all-ones value instead of wrapping.
module aoi221_exerciser_sat_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count mismatches; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/aoi221_exerciser.sv
// AOI221 self-test sequencer: walks all 32 input vectors, waits a settle
// interval per vector, samples zn against the reference and counts mismatches.
// Optional first-failure capture is enabled by AOI221_EXERCISER_FAIL_LOG_EN.
module aoi221_exerciser
    import aoi221_exerciser_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 6
) (
    input  logic               clk,
    input  logic               rst,
    aoi221_exerciser_if.master bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]    VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

    state_t               state_q;
    state_t               state_d;
    logic [VEC_W-1:0]     vec_q;
    logic [SETTLE_W-1:0]  settle_q;
    logic [VEC_W-1:0]     drive_q;
    logic                 load_run;
    logic                 mismatch;
    logic [ERR_CNT_W-1:0] err_cnt;

    // State register; reset aborts any run and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; start is honoured only in IDLE or DONE.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        load_run = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = SETTLE;
                    load_run = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                state_d = (vec_q == VEC_LAST) ? DONE : SETTLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Case-inequality so an unknown zn in simulation counts as a failure.
    assign mismatch = (state_q == SAMPLE) && (bus.zn !== aoi221_expect(vec_q));

    // Vector, settle and drive registers; drives follow vec on the same edge
    // and drop back to zero once the last vector has been sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q    <= '0;
            settle_q <= '0;
            drive_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (load_run) begin
                        vec_q    <= '0;
                        settle_q <= '0;
                        drive_q  <= '0;
                    end
                end
                SETTLE: begin
                    settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + SETTLE_W'(1);
                end
                SAMPLE: begin
                    if (vec_q != VEC_LAST) begin
                        vec_q   <= vec_q + VEC_W'(1);
                        drive_q <= vec_q + VEC_W'(1);
                    end else begin
                        drive_q <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    aoi221_exerciser_sat_cnt #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (load_run),
        .inc (mismatch),
        .cnt (err_cnt)
    );

`ifdef AOI221_EXERCISER_FAIL_LOG_EN
    logic [VEC_W-1:0] fail_vec_q;

    // Capture the first failing vector; a zero error count marks "none yet"
    // because the saturating counter never returns to zero within a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_vec_q <= '0;
        end else if (load_run) begin
            fail_vec_q <= '0;
        end else if (mismatch && (err_cnt == '0)) begin
            fail_vec_q <= vec_q;
        end
    end

    assign bus.fail_vec = fail_vec_q;
`else
    assign bus.fail_vec = '0;
`endif

    assign {bus.a1, bus.a2, bus.b1, bus.b2, bus.c} = drive_q;
    assign bus.busy    = (state_q == SETTLE) || (state_q == SAMPLE);
    assign bus.done    = (state_q == DONE);
    assign bus.pass    = (state_q == DONE) && (err_cnt == '0);
    assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_aoi221_exerciser.sv
// Bench for aoi221_exerciser: two instances (6-bit and 4-bit error counters)
// run in lockstep against a behavioural cell with selectable faults.
module tb_aoi221_exerciser;

    localparam int RUN_LEN = 96;
    localparam int BUDGET  = 2000;

    localparam int M_GOOD   = 0;
    localparam int M_STUCK1 = 1;
    localparam int M_STUCK0 = 2;
    localparam int M_INVERT = 3;
    localparam int M_RANDOM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    int          mode;
    logic [31:0] flip_mask;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    aoi221_exerciser_if #(.ERR_CNT_W(6)) bus6 ();
    aoi221_exerciser_if #(.ERR_CNT_W(4)) bus4 ();

    // Reference: output low whenever any product term is true.
    function automatic logic ref_zn(input int v);
        int a1, a2, b1, b2, c;
        a1 = (v >> 4) & 1;
        a2 = (v >> 3) & 1;
        b1 = (v >> 2) & 1;
        b2 = (v >> 1) & 1;
        c  = v & 1;
        return (a1 * a2 + b1 * b2 + c) == 0;
    endfunction

    // Cell under test, with a fault selected by m.
    function automatic logic cell_zn(input logic [4:0] v, input int m, input logic [31:0] mask);
        logic r;
        r = ref_zn(int'(v));
        case (m)
            M_STUCK1: return 1'b1;
            M_STUCK0: return 1'b0;
            M_INVERT: return !r;
            M_RANDOM: return r ^ mask[v];
            default:  return r;
        endcase
    endfunction

    assign bus6.start = start;
    assign bus4.start = start;
    assign bus6.zn = cell_zn({bus6.a1, bus6.a2, bus6.b1, bus6.b2, bus6.c}, mode, flip_mask);
    assign bus4.zn = cell_zn({bus4.a1, bus4.a2, bus4.b1, bus4.b2, bus4.c}, mode, flip_mask);

    aoi221_exerciser #(.SETTLE_CYCLES(2), .ERR_CNT_W(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .bus (bus6.master)
    );

    aoi221_exerciser #(.SETTLE_CYCLES(2), .ERR_CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.master)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Errors and first failing vector over vectors [0, upto) for a fault mode.
    task automatic model(input int m, input int upto, output int errs, output int first);
        errs  = 0;
        first = -1;
        for (int v = 0; v < upto; v++) begin
            if (cell_zn(5'(v), m, flip_mask) != ref_zn(v)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".busy6"}, 32'(bus6.busy), 0);
        check({tag, ".done6"}, 32'(bus6.done), 0);
        check({tag, ".pass6"}, 32'(bus6.pass), 0);
        check({tag, ".err6"}, 32'(bus6.err_cnt), 0);
        check({tag, ".fv6"}, 32'(bus6.fail_vec), 0);
        check({tag, ".drv6"}, 32'({bus6.a1, bus6.a2, bus6.b1, bus6.b2, bus6.c}), 0);
        check({tag, ".busy4"}, 32'(bus4.busy), 0);
        check({tag, ".err4"}, 32'(bus4.err_cnt), 0);
    endtask

    // One full run; start is re-pulsed at busy cycle poke_at (negative = never).
    task automatic run_case(input string tag, input int m, input int poke_at);
        int cycles;
        int errs;
        int first;
        int exp_fv;
        mode = m;
        start_pulse();
        check({tag, ".clr_err"}, 32'(bus6.err_cnt), 0);
        check({tag, ".clr_fv"}, 32'(bus6.fail_vec), 0);
        cycles = 0;
        while (!bus6.done && cycles < BUDGET) begin
            if (bus6.busy) cycles++;
            @(negedge clk);
            start = (cycles == poke_at);
        end
        start = 1'b0;
        model(m, 32, errs, first);
`ifdef AOI221_EXERCISER_FAIL_LOG_EN
        exp_fv = (first < 0) ? 0 : first;
`else
        exp_fv = 0;
`endif
        check({tag, ".len"}, 32'(cycles), RUN_LEN);
        check({tag, ".done"}, 32'(bus6.done), 1);
        check({tag, ".busy"}, 32'(bus6.busy), 0);
        check({tag, ".pass"}, 32'(bus6.pass), (errs == 0) ? 1 : 0);
        check({tag, ".err6"}, 32'(bus6.err_cnt), 32'(errs));
        check({tag, ".err4"}, 32'(bus4.err_cnt), 32'((errs > 15) ? 15 : errs));
        check({tag, ".fv6"}, 32'(bus6.fail_vec), 32'(exp_fv));
        check({tag, ".fv4"}, 32'(bus4.fail_vec), 32'(exp_fv));
        check({tag, ".drv"}, 32'({bus6.a1, bus6.a2, bus6.b1, bus6.b2, bus6.c}), 0);
    endtask

    initial begin
        int n;
        int errs;
        int first;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = M_GOOD;
        flip_mask = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // Directed fault modes.
        run_case("good", M_GOOD, -1);
        run_case("stuck1", M_STUCK1, -1);
        run_case("stuck0", M_STUCK0, -1);
        run_case("invert", M_INVERT, -1);

        // Random single-vector flips.
        for (int r = 0; r < 3; r++) begin
            flip_mask = $urandom();
            run_case($sformatf("rand%0d", r), M_RANDOM, -1);
        end

        // Start during a run is ignored.
        run_case("poke", M_GOOD, 40);

        // Reset mid-run at vector 10.
        mode = M_STUCK1;
        start_pulse();
        n = 0;
        while ({bus6.a1, bus6.a2, bus6.b1, bus6.b2, bus6.c} != 5'd10 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        model(M_STUCK1, 10, errs, first);
        check("abort.vec", 32'({bus6.a1, bus6.a2, bus6.b1, bus6.b2, bus6.c}), 10);
        check("abort.pre", 32'(bus6.err_cnt), 32'(errs));
        #2 rst = 1'b1;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        run_case("after_abort", M_GOOD, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aoi221_exerciser.md
Name: aoi221_exerciser

Overview:
- Self-test sequencer that drives the five inputs of an AOI221 standard cell instance (A1, A2, B1, B2, C) and checks its ZN output against the reference function ZN = !((A1&A2)|(B1&B2)|C).
- Walks all 32 input vectors, waits a settle interval, samples ZN, counts mismatches and reports pass or fail.
- Sits beside cell instances in the library silicon-validation and characterization harness.

Parameters:
- SETTLE_CYCLES, 2: cycles each vector is held before ZN is sampled; legal range 1..15.
- ERR_CNT_W, 6: width of the mismatch counter; the counter saturates.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request to begin a run; sampled only in IDLE or DONE.
- A1, A2, B1, B2, C  output  1 each  registered drive to the cell under test.
- ZN  input  1  output of the cell under test.
- BUSY  output  1  high while a run is in progress.
- DONE  output  1  high from run completion until the next START.
- PASS  output  1  valid when DONE=1; high iff ERR_CNT==0.
- ERR_CNT  output  ERR_CNT_W  number of mismatching vectors.
- FAIL_VEC  output  5  first failing vector as {A1,A2,B1,B2,C} (see Optional Feature).

Behaviour:
- Reset: while RST=1, all outputs are 0, the state is IDLE, and the vector and settle counters are 0. Assertion mid-run aborts the run immediately. There is no resume.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, START=1: go to SETTLE. Clear ERR_CNT and FAIL_VEC. Set vec=0. BUSY=1 from the next cycle.
- Vector mapping: {A1,A2,B1,B2,C} = vec[4:0]. The drive registers update on the same edge that loads vec.
- SETTLE: stays SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE: one cycle. Compare ZN with expected. On mismatch, ERR_CNT increments, holding at 2^ERR_CNT_W-1.
  - If vec<31: vec increments and the state returns to SETTLE.
  - If vec==31: go to DONE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. A full run is 32*(SETTLE_CYCLES+1) cycles from the first BUSY cycle to the DONE rise.
- DONE: BUSY=0, DONE=1, PASS=(ERR_CNT==0). Drive outputs return to 0. ERR_CNT and FAIL_VEC hold their values. START=1 clears the results and begins a new run exactly as from IDLE.
- START while BUSY is ignored.
- An X on ZN compares as a mismatch in simulation.

Optional Feature:
- Macro AOI221_EXERCISER_FAIL_LOG_EN.
- Defined: FAIL_VEC captures the vec value of the first mismatch of a run; later mismatches do not overwrite it. It reads 0 until the first failure.
- Undefined: FAIL_VEC is tied to 0 and the capture register is absent. The port list is unchanged either way.

Decomposition:
- Shared package aoi221_exerciser_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - NUM_VECTORS=32 and VEC_W=5;
  - function aoi221_expect(vec) returning the reference ZN.
- One natural sub-module: aoi221_exerciser_sat_cnt, the saturating, clearable error counter of width ERR_CNT_W.
- FSM, vector counter and settle counter stay in the top module.

Test Plan:
- Correct behavioural AOI221 wired in, SETTLE_CYCLES=2, START pulse → BUSY for exactly 96 cycles, then DONE=1, PASS=1, ERR_CNT=0, FAIL_VEC=0.
- ZN stuck at 1 → ERR_CNT=23, PASS=0, FAIL_VEC=5'b00001 with FAIL_LOG_EN. Without the macro, FAIL_VEC=0.
- ZN stuck at 0 → ERR_CNT=9, FAIL_VEC=5'b00000. Inverted ZN → ERR_CNT=32.
- ERR_CNT_W=4 with inverted ZN → ERR_CNT saturates at 15 and does not wrap.
- RST pulsed while vec=10 → all outputs 0 asynchronously. A following START completes a clean 96-cycle run with PASS=1.
- START pulsed mid-run → ignored and run length unchanged. START in DONE → ERR_CNT and FAIL_VEC cleared and a new run starts.
